// File: rtl/gshare_btb_2way_pkg.sv
// gshare_btb_2way_pkg: shared counter encodings, BTB entry layout and PC width.
package gshare_btb_2way_pkg;
  localparam int PC_W = 32;
  localparam int TAG_W = 30;
  typedef struct packed {
    logic valid;
    logic is_jump;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0] target;
  } btb_entry_t;
  function automatic int ctr_strong_taken(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int ctr_weak_taken(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int ctr_weak_not_taken(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int ctr_strong_not_taken(input int w);
    return w - w;
  endfunction
endpackage

// File: rtl/gshare_btb_2way_btb_2way.sv
// gshare_btb_2way_btb_2way: 2-way set-associative BTB with per-set LRU and invalid-first allocation.
module gshare_btb_2way_btb_2way
  import gshare_btb_2way_pkg::*;
#(
  parameter int SET_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [29:0]     lookup_pc,
  output logic            hit,
  output logic [PC_W-1:0] hit_target,
  output logic            hit_is_jump,
  input  logic            wr_en,
  input  logic [29:0]     wr_pc,
  input  logic [PC_W-1:0] wr_target,
  input  logic            wr_is_jump
);
  localparam int SETS = 1 << SET_BITS;
  btb_entry_t mem [2][SETS];
  logic [SETS-1:0] lru;
  logic [SET_BITS-1:0] ls, ws;
  logic [1:0] lh, wh;
  logic way;
  function automatic logic [TAG_W-1:0] tag_of(input logic [29:0] p);
    return TAG_W'(p[29:SET_BITS]);
  endfunction
  always_comb begin
    ls = lookup_pc[SET_BITS-1:0];
    ws = wr_pc[SET_BITS-1:0];
    lh = '0;
    wh = '0;
    for (int w = 0; w < 2; w++) begin
      lh[w] = mem[w][ls].valid && mem[w][ls].tag == tag_of(lookup_pc);
      wh[w] = mem[w][ws].valid && mem[w][ws].tag == tag_of(wr_pc);
    end
    way = wh[0] ? 1'b0 : wh[1] ? 1'b1 : !mem[0][ws].valid ? 1'b0 :
          !mem[1][ws].valid ? 1'b1 : lru[ws];
  end
  assign hit = |lh;
  assign hit_target = lh[0] ? mem[0][ls].target : mem[1][ls].target;
  assign hit_is_jump = lh[0] ? mem[0][ls].is_jump : mem[1][ls].is_jump;
  // lru[s] names the way to evict next; only valid bits need clearing on reset
  always_ff @(posedge clk)
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        mem[0][s].valid <= 1'b0;
        mem[1][s].valid <= 1'b0;
      end
      lru <= '0;
    end else if (wr_en) begin
      mem[way][ws] <= '{valid: 1'b1, is_jump: wr_is_jump, tag: tag_of(wr_pc), target: wr_target};
      lru[ws] <= ~way;
    end
endmodule

// File: rtl/gshare_btb_2way.sv
// gshare_btb_2way: gshare direction predictor with 2-way BTB, speculative history and mispredict recovery.
module gshare_btb_2way
  import gshare_btb_2way_pkg::*;
#(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 6,
  parameter int SET_BITS  = 4,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          fetch_pc,
  input  logic                 fetch_valid,
  output logic                 pred_taken,
  output logic [31:0]          pred_pc,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 resolve_valid,
  input  logic [31:0]          resolve_pc,
  input  logic                 resolve_is_cond,
  input  logic                 resolve_taken,
  input  logic [31:0]          resolve_target,
  input  logic [HIST_BITS-1:0] resolve_ghr,
  input  logic                 resolve_mispredict
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_ST  = CTR_BITS'(ctr_strong_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_SNT = CTR_BITS'(ctr_strong_not_taken(CTR_BITS));
  logic [CTR_BITS-1:0] pht [ENTRIES];
  logic [HIST_BITS-1:0] ghr_spec;
  logic hit, hit_is_jump;
  logic [PC_W-1:0] hit_target;
  logic [IDX_BITS-1:0] fetch_idx, train_idx;
  logic [CTR_BITS-1:0] ctr, train_ctr;
  logic unused_bits;
  assign unused_bits = ^resolve_pc[1:0];
  assign fetch_idx = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_spec);
  assign train_idx = resolve_pc[IDX_BITS+1:2] ^ IDX_BITS'(resolve_ghr);
  assign ctr = pht[fetch_idx];
  assign train_ctr = pht[train_idx];
  gshare_btb_2way_btb_2way #(.SET_BITS(SET_BITS)) btb (
    .clk(clk),
    .reset(reset),
    .lookup_pc(fetch_pc[31:2]),
    .hit(hit),
    .hit_target(hit_target),
    .hit_is_jump(hit_is_jump),
    .wr_en(resolve_valid && resolve_taken),
    .wr_pc(resolve_pc[31:2]),
    .wr_target(resolve_target),
    .wr_is_jump(!resolve_is_cond)
  );
  assign pred_taken = !reset && hit && (hit_is_jump || ctr[CTR_BITS-1]);
  assign pred_pc = pred_taken ? hit_target : fetch_pc + PC_W'(4);
  assign pred_ghr = reset ? '0 : ghr_spec;
  // the truncating casts shift one bit into the history and also cover HIST_BITS == 1
  always_ff @(posedge clk)
    if (reset) ghr_spec <= '0;
    else if (resolve_valid && resolve_mispredict)
      ghr_spec <= resolve_is_cond ? HIST_BITS'({resolve_ghr, resolve_taken}) : resolve_ghr;
    else if (fetch_valid && hit && !hit_is_jump)
      ghr_spec <= HIST_BITS'({ghr_spec, pred_taken});
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_WT;
    end else if (resolve_valid && resolve_is_cond)
      pht[train_idx] <= resolve_taken ? (train_ctr == CTR_ST ? train_ctr : train_ctr + CTR_BITS'(1))
                                      : (train_ctr == CTR_SNT ? train_ctr : train_ctr - CTR_BITS'(1));
endmodule

// File: tb/tb_gshare_btb_2way.sv
// tb_gshare_btb_2way: directed vectors with a queued scoreboard checked mid-cycle by a monitor.
module tb_gshare_btb_2way;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] fetch_pc;
  logic fetch_valid;
  logic pred_taken;
  logic [31:0] pred_pc;
  logic [3:0] pred_ghr;
  logic resolve_valid, resolve_is_cond, resolve_taken, resolve_mispredict;
  logic [31:0] resolve_pc, resolve_target;
  logic [3:0] resolve_ghr;

  always #5 clk = ~clk;

  gshare_btb_2way #(.IDX_BITS(6), .HIST_BITS(4), .SET_BITS(4), .CTR_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid),
    .pred_taken(pred_taken),
    .pred_pc(pred_pc),
    .pred_ghr(pred_ghr),
    .resolve_valid(resolve_valid),
    .resolve_pc(resolve_pc),
    .resolve_is_cond(resolve_is_cond),
    .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .resolve_ghr(resolve_ghr),
    .resolve_mispredict(resolve_mispredict)
  );

  typedef struct {
    string name;
    logic t;
    logic [31:0] pc;
    logic [3:0] g;
  } exp_t;
  exp_t q[$];
  logic chk = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always @(negedge clk)
    if (chk) begin
      exp_t e;
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_underflow: output presented with no expected entry");
      end else begin
        e = q.pop_front();
        if (pred_taken !== e.t || pred_pc !== e.pc || pred_ghr !== e.g) begin
          mismatched++;
          $display("FAIL %s: got taken=%0b pc=%h ghr=%b, want taken=%0b pc=%h ghr=%b",
                   e.name, pred_taken, pred_pc, pred_ghr, e.t, e.pc, e.g);
        end
      end
    end

  task automatic fe(input logic [31:0] pc, input logic fv);
    fetch_pc = pc;
    fetch_valid = fv;
  endtask

  task automatic rs(input logic [31:0] pc, input logic cond, input logic tk,
                    input logic [31:0] tgt, input logic [3:0] g, input logic mis);
    resolve_valid = 1'b1;
    resolve_pc = pc;
    resolve_is_cond = cond;
    resolve_taken = tk;
    resolve_target = tgt;
    resolve_ghr = g;
    resolve_mispredict = mis;
  endtask

  task automatic step(input string nm, input logic c, input logic t,
                      input logic [31:0] pc, input logic [3:0] g);
    exp_t e;
    if (c) begin
      e.name = nm;
      e.t = t;
      e.pc = pc;
      e.g = g;
      q.push_back(e);
    end
    chk = c;
    @(posedge clk);
    #1;
    chk = 1'b0;
    fetch_valid = 1'b0;
    resolve_valid = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    fe(32'h0, 1'b0);
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_is_cond = 1'b0;
    resolve_taken = 1'b0;
    resolve_target = '0;
    resolve_ghr = '0;
    resolve_mispredict = 1'b0;
    @(posedge clk);
    #1;
    fe(32'h100, 1'b0);
    rs(32'h100, 1'b1, 1'b1, 32'h80, 4'h0, 1'b0);
    step("in_reset", 1'b1, 1'b0, 32'h104, 4'h0);
    reset = 1'b0;
    step("post_reset", 1'b1, 1'b0, 32'h104, 4'h0);
    rs(32'h100, 1'b1, 1'b1, 32'h80, 4'h0, 1'b0);
    step("no_bypass", 1'b1, 1'b0, 32'h104, 4'h0);
    step("cond_taken", 1'b1, 1'b1, 32'h80, 4'h0);
    rs(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    step("nt1_old", 1'b1, 1'b1, 32'h80, 4'h0);
    rs(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    step("nt2_old", 1'b1, 1'b1, 32'h80, 4'h0);
    step("after_two_nt", 1'b1, 1'b0, 32'h104, 4'h0);
    rs(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    step("sat_a", 1'b1, 1'b0, 32'h104, 4'h0);
    rs(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    step("sat_b", 1'b1, 1'b0, 32'h104, 4'h0);
    step("sat_hold", 1'b1, 1'b0, 32'h104, 4'h0);
    rs(32'h200, 1'b0, 1'b1, 32'h400, 4'h0, 1'b0);
    step("jal_train", 1'b1, 1'b0, 32'h104, 4'h0);
    fe(32'h200, 1'b1);
    step("jal_pred1", 1'b1, 1'b1, 32'h400, 4'h0);
    fe(32'h200, 1'b1);
    step("jal_pred2", 1'b1, 1'b1, 32'h400, 4'h0);
    reset = 1'b1;
    fe(32'h200, 1'b0);
    rs(32'h300, 1'b0, 1'b1, 32'h600, 4'h0, 1'b0);
    step("mid_reset", 1'b1, 1'b0, 32'h204, 4'h0);
    reset = 1'b0;
    step("flush_jal", 1'b1, 1'b0, 32'h204, 4'h0);
    fe(32'h100, 1'b0);
    step("flush_cond", 1'b1, 1'b0, 32'h104, 4'h0);
    fe(32'h300, 1'b0);
    step("reset_ignores_resolve", 1'b1, 1'b0, 32'h304, 4'h0);
    fe(32'h100, 1'b0);
    rs(32'h100, 1'b1, 1'b1, 32'h80, 4'h1, 1'b0);
    step("realloc", 1'b1, 1'b0, 32'h104, 4'h0);
    step("ctr_weak_taken", 1'b1, 1'b1, 32'h80, 4'h0);
    rs(32'h140, 1'b1, 1'b1, 32'h500, 4'h0, 1'b0);
    step("", 1'b0, 1'b0, 32'h0, 4'h0);
    rs(32'h180, 1'b1, 1'b1, 32'h600, 4'h0, 1'b0);
    step("", 1'b0, 1'b0, 32'h0, 4'h0);
    fe(32'h100, 1'b0);
    step("evicted", 1'b1, 1'b0, 32'h104, 4'h0);
    fe(32'h140, 1'b0);
    step("way1_hit", 1'b1, 1'b1, 32'h500, 4'h0);
    fe(32'h180, 1'b0);
    step("way0_hit", 1'b1, 1'b1, 32'h600, 4'h0);
    rs(32'h140, 1'b1, 1'b1, 32'h540, 4'h0, 1'b0);
    step("", 1'b0, 1'b0, 32'h0, 4'h0);
    rs(32'h1C0, 1'b1, 1'b1, 32'h700, 4'h0, 1'b0);
    step("", 1'b0, 1'b0, 32'h0, 4'h0);
    fe(32'h180, 1'b0);
    step("lru_victim", 1'b1, 1'b0, 32'h184, 4'h0);
    fe(32'h140, 1'b0);
    step("retarget", 1'b1, 1'b1, 32'h540, 4'h0);
    fe(32'h1C0, 1'b0);
    step("new_alloc", 1'b1, 1'b1, 32'h700, 4'h0);
    fe(32'h140, 1'b1);
    step("spec1", 1'b1, 1'b1, 32'h540, 4'h0);
    fe(32'h1C0, 1'b1);
    step("spec2", 1'b1, 1'b1, 32'h700, 4'h1);
    fe(32'h1C0, 1'b1);
    step("spec3", 1'b1, 1'b1, 32'h700, 4'h3);
    fe(32'h1C0, 1'b1);
    rs(32'h1C0, 1'b1, 1'b0, 32'h0, 4'b0001, 1'b1);
    step("spec4", 1'b1, 1'b1, 32'h700, 4'h7);
    fe(32'h1C0, 1'b0);
    step("recovered", 1'b1, 1'b1, 32'h700, 4'b0010);
    rs(32'h204, 1'b0, 1'b1, 32'h800, 4'b1010, 1'b1);
    step("jal_mis", 1'b1, 1'b1, 32'h700, 4'b0010);
    fe(32'h204, 1'b0);
    step("jal_recover", 1'b1, 1'b1, 32'h800, 4'b1010);
    fe(32'hFFFF_FFFC, 1'b0);
    step("wrap", 1'b1, 1'b0, 32'h0, 4'b1010);
    step("", 1'b0, 1'b0, 32'h0, 4'h0);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
